// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
// Sits on the CPU data bus next to the RAM and decodes its own IO page.
// Bytes written to DATA are queued in a small FIFO, and a serialiser FSM
// sends them out on uart_tx. STATUS reports busy/full/empty and a sticky
// overflow flag.
module uart_tx_mmio #(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int IO_BIT     = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------
    // Reset: asserted immediately, released on a clock edge through a
    // two-flop synchroniser so all state leaves reset in the same cycle.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_r;
    logic       rst_int_n_s;

    // Reset synchroniser: async clear, synchronous release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel_s;
    logic [1:0] reg_idx_s;
    logic       wr_s;
    logic       rd_s;
    logic       push_req_s;
    logic       ovf_clr_s;
    logic       unused_bus_s;

    assign sel_s      = mem_addr[IO_BIT];
    assign reg_idx_s  = mem_addr[3:2];
    assign wr_s       = sel_s && (mem_wmask != 4'b0000);
    assign rd_s       = sel_s && mem_rstrb;
    assign push_req_s = wr_s && (reg_idx_s == 2'd0) && mem_wmask[0];
    assign ovf_clr_s  = wr_s && (reg_idx_s == 2'd1);

    // Address/data bits outside the decoded fields are deliberately ignored.
    assign unused_bus_s = ^{mem_addr, mem_wdata[31:8]};

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [7:0]     fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_n_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             push_s;
    logic             pop_s;
    logic [7:0]       fifo_head_s;

    assign fifo_empty_s = (count_r == '0);
    assign fifo_full_s  = (count_r == CNT_FULL);
    // Fullness is judged at the start of the cycle, so a same-cycle pop
    // never makes room for a push.
    assign push_s       = push_req_s && !fifo_full_s;
    assign fifo_head_s  = fifo_mem_r[rd_ptr_r];

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    tx_state_t        state_r;
    tx_state_t        state_n_s;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [CNT_W-1:0] baud_cnt_n_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_n_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_n_s;
    logic             tx_d_s;
    logic             busy_d_s;
    logic             overflow_r;
    logic [31:0]      rdata_d_s;

    // Serialiser next-state: frame sequencing, baud timing and FIFO pop.
    always_comb begin
        state_n_s    = state_r;
        baud_cnt_n_s = baud_cnt_r;
        bit_idx_n_s  = bit_idx_r;
        shift_n_s    = shift_r;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shift_n_s    = fifo_head_s;
                    baud_cnt_n_s = '0;
                    state_n_s    = ST_START;
                end else begin
                    baud_cnt_n_s = '0;
                end
            end
            ST_START: begin
                if (baud_cnt_r == CNT_LAST) begin
                    baud_cnt_n_s = '0;
                    bit_idx_n_s  = 3'd0;
                    state_n_s    = ST_DATA;
                end else begin
                    baud_cnt_n_s = baud_cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_cnt_r == CNT_LAST) begin
                    baud_cnt_n_s = '0;
                    shift_n_s    = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_n_s = ST_STOP;
                    end else begin
                        bit_idx_n_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_cnt_n_s = baud_cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_cnt_r == CNT_LAST) begin
                    baud_cnt_n_s = '0;
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty_s) begin
                        pop_s     = 1'b1;
                        shift_n_s = fifo_head_s;
                        state_n_s = ST_START;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end else begin
                    baud_cnt_n_s = baud_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_n_s    = ST_IDLE;
                baud_cnt_n_s = '0;
            end
        endcase
    end

    // Line level for the next cycle, derived from the next state so the
    // registered pin lines up exactly with the state it represents.
    always_comb begin
        tx_d_s = 1'b1;
        case (state_n_s)
            ST_START: tx_d_s = 1'b0;
            ST_DATA:  tx_d_s = shift_n_s[0];
            ST_STOP:  tx_d_s = 1'b1;
            default:  tx_d_s = 1'b1;
        endcase
    end

    // FIFO occupancy update from the accepted push and the FSM pop.
    always_comb begin
        count_n_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_n_s = count_r + CNT_ONE;
            2'b01:   count_n_s = count_r - CNT_ONE;
            default: count_n_s = count_r;
        endcase
    end

    assign busy_d_s = (state_n_s != ST_IDLE) || (count_n_s != '0);

    // Register read mux; DATA and reserved slots read as zero.
    always_comb begin
        rdata_d_s = 32'd0;
        case (reg_idx_s)
            2'd1:    rdata_d_s = {28'd0, overflow_r, fifo_empty_s, fifo_full_s, tx_busy};
            default: rdata_d_s = 32'd0;
        endcase
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_n_s;
        end
    end

    // FIFO storage; flushed on reset so no stale byte can be replayed.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'd0;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= mem_wdata[7:0];
        end
    end

    // Serialiser state register.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
        end else begin
            state_r    <= state_n_s;
            baud_cnt_r <= baud_cnt_n_s;
            bit_idx_r  <= bit_idx_n_s;
            shift_r    <= shift_n_s;
        end
    end

    // Registered line driver and busy flag (glitch-free outputs).
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            uart_tx <= tx_d_s;
            tx_busy <= busy_d_s;
        end
    end

    // Sticky overflow: set by a dropped push, cleared by any STATUS write.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            overflow_r <= 1'b0;
        end else if (push_req_s && fifo_full_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr_s) begin
            overflow_r <= 1'b0;
        end
    end

    // Read data register; holds its value between selected reads.
    always_ff @(posedge clk or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            mem_rdata <= 32'd0;
        end else if (rd_s) begin
            mem_rdata <= rdata_d_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with DIV = 10 (CLK_HZ=1000, BAUD=100).
module tb_uart_tx_mmio;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int total;
    int bad;

    uart_tx_mmio #(
        .CLK_HZ(1000),
        .BAUD(100),
        .FIFO_DEPTH(4),
        .IO_BIT(22)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb),
        .mem_rdata(mem_rdata),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        tick();
        mem_wmask = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        tick();
        mem_rstrb = 1'b0;
        mem_addr  = 32'h0;
    endtask

    // Expects to be called on the first cycle of the start bit.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 10; c++) begin
                chk(tag, {31'd0, uart_tx}, {31'd0, frame[k]});
                tick();
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;

        // Reset state.
        repeat (3) tick();
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            chk("idle_tx", {31'd0, uart_tx}, 32'd1);
            tick();
        end
        chk("idle_busy", {31'd0, tx_busy}, 32'd0);
        rd(32'h0040_0004);
        chk("idle_status", mem_rdata, 32'h4);

        // Single byte 0x55.
        wr(32'h0040_0000, 32'h55, 4'h1);
        chk("pre_start_tx", {31'd0, uart_tx}, 32'd1);
        chk("pre_start_busy", {31'd0, tx_busy}, 32'd1);
        tick();
        check_frame(8'h55, "frame_55");
        chk("after_55_busy", {31'd0, tx_busy}, 32'd0);
        chk("after_55_tx", {31'd0, uart_tx}, 32'd1);

        // Back-to-back frames without idle gap.
        wr(32'h0040_0000, 32'hA5, 4'h1);
        wr(32'h0040_0000, 32'h3C, 4'h1);
        check_frame(8'hA5, "frame_a5");
        check_frame(8'h3C, "frame_3c");
        chk("after_3c_busy", {31'd0, tx_busy}, 32'd0);

        // Overflow: six writes, five accepted.
        wr(32'h0040_0000, 32'h11, 4'h1);
        wr(32'h0040_0000, 32'h22, 4'h1);
        wr(32'h0040_0000, 32'h33, 4'h1);
        wr(32'h0040_0000, 32'h44, 4'h1);
        wr(32'h0040_0000, 32'h55, 4'h1);
        wr(32'h0040_0000, 32'h66, 4'h1);
        rd(32'h0040_0004);
        chk("status_ovf", mem_rdata, 32'hB);
        wr(32'h0040_0004, 32'h0, 4'hF);
        rd(32'h0040_0004);
        chk("status_full", mem_rdata, 32'h3);
        rd(32'h0000_0004);
        chk("unsel_read_hold", mem_rdata, 32'h3);
        rd(32'h0040_0008);
        chk("reserved_read", mem_rdata, 32'h0);
        wr(32'h0000_0000, 32'h77, 4'hF);
        rd(32'h0040_0004);
        chk("ram_write_ignored", mem_rdata, 32'h3);
        // First frame started one edge after the first write; the next
        // starts 100 edges later. Twelve edges have elapsed since then.
        repeat (101 - 12) tick();
        check_frame(8'h22, "frame_22");
        check_frame(8'h33, "frame_33");
        check_frame(8'h44, "frame_44");
        check_frame(8'h55, "frame_55b");
        chk("after_burst_busy", {31'd0, tx_busy}, 32'd0);
        rd(32'h0040_0004);
        chk("after_burst_status", mem_rdata, 32'h4);

        // Reset in the middle of data bit 3 of 0xF0 (bit value 0).
        wr(32'h0040_0000, 32'hF0, 4'h1);
        wr(32'h0040_0000, 32'h0F, 4'h1);
        repeat (44) tick();
        chk("bit3_low", {31'd0, uart_tx}, 32'd0);
        chk("bit3_busy", {31'd0, tx_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("async_rst_busy", {31'd0, tx_busy}, 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        rd(32'h0040_0004);
        chk("post_rst_status", mem_rdata, 32'h4);
        for (int i = 0; i < 150; i++) begin
            chk("post_rst_tx", {31'd0, uart_tx}, 32'd1);
            tick();
        end
        chk("post_rst_busy", {31'd0, tx_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
